// File: rtl/vote_controller_pkg.sv
// Shared definitions for the three-judge voting round controller.
// State codes, judge count and counter sizing helper.
package vote_controller_pkg;

  localparam int N_JUDGES = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // Width able to hold 0..max(a,b)-1, never below one bit.
  function automatic int cnt_width(input int a, input int b);
    int w;
    w = 1;
    if ($clog2(a) > w) w = $clog2(a);
    if ($clog2(b) > w) w = $clog2(b);
    return w;
  endfunction

endpackage

// File: rtl/vote_controller_judge3.sv
// Existing 2-of-3 majority voter.
// Purely combinational.
module judge3 (
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic out
);

  assign out = (in1 & in2) | (in1 & in3) | (in2 & in3);

endmodule

// File: rtl/vote_controller.sv
// Sequences one voting round: collect ballots, decide, hold verdict.
// Timer doubles as collect timeout and hold counter.
module vote_controller
  import vote_controller_pkg::*;
#(
  parameter int TIMEOUT     = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_JUDGES-1:0] vote_en,
  input  logic [N_JUDGES-1:0] vote_yes,
  output logic                busy,
  output logic [N_JUDGES-1:0] voted,
  output logic                result,
  output logic                result_valid,
  output logic                timed_out
);

  localparam int CNT_W = cnt_width(TIMEOUT, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e              state_q;
  logic [N_JUDGES-1:0] ballot_q, ballot_d;
  logic [N_JUDGES-1:0] voted_q, voted_d;
  logic [CNT_W-1:0]    timer_q;
  logic                result_q;
  logic                result_valid_q;
  logic                timed_out_q;
  logic                verdict;

  judge3 u_judge3 (
    .in1 (ballot_q[0]),
    .in2 (ballot_q[1]),
    .in3 (ballot_q[2]),
    .out (verdict)
  );

  // First strobe per judge latches its ballot; later strobes are dropped.
  always_comb begin
    ballot_d = ballot_q;
    voted_d  = voted_q | vote_en;
    for (int i = 0; i < N_JUDGES; i++) begin
      if (vote_en[i] && !voted_q[i]) ballot_d[i] = vote_yes[i];
    end
  end

  // Round state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ballot_q       <= '0;
      voted_q        <= '0;
      timer_q        <= '0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
      timed_out_q    <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_COLLECT;
            ballot_q    <= '0;
            voted_q     <= '0;
            timer_q     <= '0;
            timed_out_q <= 1'b0;
          end
        end
        ST_COLLECT: begin
          ballot_q <= ballot_d;
          voted_q  <= voted_d;
          if (&voted_d) begin
            state_q <= ST_DECIDE;
          end else if (timer_q == TO_LAST) begin
            state_q     <= ST_DECIDE;
            timed_out_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          result_q       <= verdict;
          result_valid_q <= 1'b1;
          timer_q        <= '0;
          state_q        <= ST_HOLD;
        end
        ST_HOLD: begin
          if (timer_q == HD_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign voted        = voted_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timed_out    = timed_out_q;

endmodule
